// File: rtl/ctrl_filtro_pa20.sv
// Sequencer for the 20 Hz high-pass biquad datapath: history shift plus five
// multiply-accumulate steps per sample, with registered enables and mux selects.
module ctrl_filtro_pa20 #(
    parameter int ARIT_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       en1,
    output logic       en2,
    output logic       en3,
    output logic       en4,
    output logic       en5,
    output logic       en6,
    output logic       en7,
    output logic [2:0] selmuxS,
    output logic [1:0] selmuxC,
    output logic [2:0] selmuxZ,
    output logic       busy,
    output logic       done,
    output logic       overrun
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_OP    = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] LAST_CNT = 2'(ARIT_LAT);

    state_t     state_r, state_s;
    logic [2:0] op_r, op_s;
    logic [1:0] cnt_r, cnt_s;
    logic [6:0] en_r, en_s, dst_s;
    logic [2:0] sels_r, sels_s, selz_r, selz_s;
    logic [1:0] selc_r, selc_s;
    logic       busy_r, busy_s, done_r, done_s, ovr_r, ovr_s;

    // Next-state logic: op index advances after the final wait cycle of each op
    always_comb begin
        state_s = state_r;
        op_s    = op_r;
        cnt_s   = cnt_r;
        case (state_r)
            S_IDLE: begin
                if (start) state_s = S_SHIFT;
                else       state_s = S_IDLE;
            end
            S_SHIFT: begin
                state_s = S_OP;
                op_s    = 3'd1;
                cnt_s   = 2'd0;
            end
            S_OP: begin
                if (cnt_r == LAST_CNT) begin
                    cnt_s = 2'd0;
                    if (op_r == 3'd5) state_s = S_DONE;
                    else              op_s    = op_r + 3'd1;
                end else begin
                    cnt_s = cnt_r + 2'd1;
                end
            end
            S_DONE: begin
                if (start) state_s = S_SHIFT;
                else       state_s = S_IDLE;
            end
            default: state_s = S_IDLE;
        endcase
    end

    // Output decode from the next state so every output can be registered
    always_comb begin
        en_s   = 7'd0;
        dst_s  = 7'd0;
        sels_s = 3'd0;
        selc_s = 2'd0;
        selz_s = 3'd0;
        busy_s = 1'b0;
        done_s = 1'b0;
        ovr_s  = start & busy_r;
        case (state_s)
            S_SHIFT: begin
                en_s   = 7'b000_1100;
                busy_s = 1'b1;
            end
            S_OP: begin
                busy_s = 1'b1;
                case (op_s)
                    3'd1: begin sels_s = 3'd1; selc_s = 2'd2; selz_s = 3'd4; dst_s = 7'b001_0000; end
                    3'd2: begin sels_s = 3'd2; selc_s = 2'd3; selz_s = 3'd1; dst_s = 7'b000_0010; end
                    3'd3: begin sels_s = 3'd0; selc_s = 2'd0; selz_s = 3'd0; dst_s = 7'b010_0000; end
                    3'd4: begin sels_s = 3'd1; selc_s = 2'd1; selz_s = 3'd2; dst_s = 7'b100_0000; end
                    3'd5: begin sels_s = 3'd2; selc_s = 2'd0; selz_s = 3'd3; dst_s = 7'b000_0001; end
                    default: dst_s = 7'd0;
                endcase
                if (cnt_s == LAST_CNT) en_s = dst_s;
                else                   en_s = 7'd0;
            end
            S_DONE: done_s = 1'b1;
            default: en_s = 7'd0;
        endcase
    end

    // State and output registers; reset abandons any sample in flight
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= S_IDLE;
            op_r    <= 3'd0;
            cnt_r   <= 2'd0;
            en_r    <= 7'd0;
            sels_r  <= 3'd0;
            selc_r  <= 2'd0;
            selz_r  <= 3'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            ovr_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            op_r    <= op_s;
            cnt_r   <= cnt_s;
            en_r    <= en_s;
            sels_r  <= sels_s;
            selc_r  <= selc_s;
            selz_r  <= selz_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            ovr_r   <= ovr_s;
        end
    end

    assign {en7, en6, en5, en4, en3, en2, en1} = en_r;
    assign selmuxS = sels_r;
    assign selmuxC = selc_r;
    assign selmuxZ = selz_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign overrun = ovr_r;

endmodule
